// File: rtl/reg_file_sb.sv
// Decode-stage register file: two combinational read ports with write bypass,
// one synchronous write port, optional hardwired r0, and a pending-write scoreboard.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic [ADDR_W-1:0] rAddr1,
  input  logic [ADDR_W-1:0] rAddr2,
  output logic [DATA_W-1:0] regData1,
  output logic [DATA_W-1:0] regData2,
  output logic              busy1,
  output logic              busy2,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              regWriteFlag,
  input  logic              resvFlag,
  input  logic [ADDR_W-1:0] resvAddr
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;

  logic wrZero, resvZero, rd1Zero, rd2Zero, hit1, hit2;

  assign wrZero   = (ZERO_REG != 0) && (wAddr == '0);
  assign resvZero = (ZERO_REG != 0) && (resvAddr == '0);
  assign rd1Zero  = (ZERO_REG != 0) && (rAddr1 == '0);
  assign rd2Zero  = (ZERO_REG != 0) && (rAddr2 == '0);
  assign hit1     = regWriteFlag && (wAddr == rAddr1);
  assign hit2     = regWriteFlag && (wAddr == rAddr2);

  always_ff @(posedge clk) begin
    if (!rstN) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pending <= '0;
    end else begin
      if (regWriteFlag && !wrZero) regs[wAddr] <= wrData;
      if (regWriteFlag) pending[wAddr] <= 1'b0;
      // Reservation follows the clear so a same-address retire/issue leaves the bit set.
      if (resvFlag && !resvZero) pending[resvAddr] <= 1'b1;
    end
  end

  always_comb begin
    regData1 = regs[rAddr1];
    if (hit1) regData1 = wrData;
    if (rd1Zero) regData1 = '0;

    regData2 = regs[rAddr2];
    if (hit2) regData2 = wrData;
    if (rd2Zero) regData2 = '0;

    busy1 = pending[rAddr1] && !hit1 && !rd1Zero;
    busy2 = pending[rAddr2] && !hit2 && !rd2Zero;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: three builds (default, ZERO_REG=0, 16x8 narrow) driven
// with directed and random traffic, each checked against an array-based model.
module tb_reg_file_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN;
  logic [31:0] wD  [3];
  logic [4:0]  rA1 [3];
  logic [4:0]  rA2 [3];
  logic [4:0]  wA  [3];
  logic [4:0]  vA  [3];
  logic        we  [3];
  logic        rv  [3];

  logic [31:0] d1a, d2a, d1b, d2b;
  logic [15:0] d1c, d2c;
  logic        b1 [3];
  logic        b2 [3];

  int dw [3] = '{32, 32, 16};
  int aw [3] = '{5, 5, 3};
  int zr [3] = '{1, 0, 1};

  logic [31:0] mRegs [3][32];
  logic        mPend [3][32];

  int nVec = 0;
  int nBad = 0;

  reg_file_sb dut (
    .clk(clk), .rstN(rstN),
    .rAddr1(rA1[0]), .rAddr2(rA2[0]), .regData1(d1a), .regData2(d2a),
    .busy1(b1[0]), .busy2(b2[0]),
    .wAddr(wA[0]), .wrData(wD[0]), .regWriteFlag(we[0]),
    .resvFlag(rv[0]), .resvAddr(vA[0])
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dutNz (
    .clk(clk), .rstN(rstN),
    .rAddr1(rA1[1]), .rAddr2(rA2[1]), .regData1(d1b), .regData2(d2b),
    .busy1(b1[1]), .busy2(b2[1]),
    .wAddr(wA[1]), .wrData(wD[1]), .regWriteFlag(we[1]),
    .resvFlag(rv[1]), .resvAddr(vA[1])
  );

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dutSmall (
    .clk(clk), .rstN(rstN),
    .rAddr1(rA1[2][2:0]), .rAddr2(rA2[2][2:0]), .regData1(d1c), .regData2(d2c),
    .busy1(b1[2]), .busy2(b2[2]),
    .wAddr(wA[2][2:0]), .wrData(wD[2][15:0]), .regWriteFlag(we[2]),
    .resvFlag(rv[2]), .resvAddr(vA[2][2:0])
  );

  task automatic chkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    if (obs !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] obsData(input int i, input int p);
    case (i)
      0:       return (p == 1) ? d1a : d2a;
      1:       return (p == 1) ? d1b : d2b;
      default: return (p == 1) ? {16'h0, d1c} : {16'h0, d2c};
    endcase
  endfunction

  function automatic logic [31:0] expData(input int i, input logic [4:0] ra);
    if (zr[i] != 0 && ra == 0) return 32'h0;
    if (we[i] && wA[i] == ra) return wD[i];
    return mRegs[i][ra];
  endfunction

  function automatic logic expBusy(input int i, input logic [4:0] ra);
    if (zr[i] != 0 && ra == 0) return 1'b0;
    return mPend[i][ra] && !(we[i] && wA[i] == ra);
  endfunction

  task automatic checkAll();
    for (int i = 0; i < 3; i++) begin
      chkVal($sformatf("data1[%0d]", i), obsData(i, 1), expData(i, rA1[i]));
      chkVal($sformatf("data2[%0d]", i), obsData(i, 2), expData(i, rA2[i]));
      chkVal($sformatf("busy1[%0d]", i), {31'h0, b1[i]}, {31'h0, expBusy(i, rA1[i])});
      chkVal($sformatf("busy2[%0d]", i), {31'h0, b2[i]}, {31'h0, expBusy(i, rA2[i])});
    end
  endtask

  task automatic updateModel();
    for (int i = 0; i < 3; i++) begin
      if (!rstN) begin
        for (int a = 0; a < 32; a++) begin
          mRegs[i][a] = 32'h0;
          mPend[i][a] = 1'b0;
        end
      end else begin
        if (we[i] && !(zr[i] != 0 && wA[i] == 0)) mRegs[i][wA[i]] = wD[i];
        if (we[i]) mPend[i][wA[i]] = 1'b0;
        if (rv[i] && !(zr[i] != 0 && vA[i] == 0)) mPend[i][vA[i]] = 1'b1;
      end
    end
  endtask

  task automatic idle();
    for (int i = 0; i < 3; i++) begin
      wD[i] = 32'h0; rA1[i] = 5'd0; rA2[i] = 5'd0;
      wA[i] = 5'd0; vA[i] = 5'd0; we[i] = 1'b0; rv[i] = 1'b0;
    end
  endtask

  // Check combinational outputs mid-cycle, then advance one edge.
  task automatic step();
    #2;
    checkAll();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  function automatic logic [4:0] randAddr(input int i);
    if (aw[i] == 5 && $urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, (1 << aw[i]) - 1));
  endfunction

  initial begin
    for (int i = 0; i < 3; i++)
      for (int a = 0; a < 32; a++) begin
        mRegs[i][a] = 32'hX;
        mPend[i][a] = 1'bX;
      end
    idle();
    rstN = 1'b0;
    @(posedge clk);
    updateModel();
    #1;
    step();
    rstN = 1'b1;
    step();

    // Reset overrides a same-edge write and discards reservations
    we[0] = 1'b1; wA[0] = 5'd5; wD[0] = 32'hDEADBEEF; rv[0] = 1'b1; vA[0] = 5'd7;
    step();
    idle();
    rstN = 1'b0; we[0] = 1'b1; wA[0] = 5'd5; wD[0] = 32'hDEADBEEF;
    step();
    rstN = 1'b1; idle();
    rA1[0] = 5'd5; rA2[0] = 5'd7;
    #1;
    chkVal("rst_data", d1a, 32'h0);
    chkVal("rst_busy", {31'h0, b2[0]}, 32'h0);
    step();

    // Write then read on both ports
    we[0] = 1'b1; wA[0] = 5'd3; wD[0] = 32'h12345678;
    step();
    idle(); rA1[0] = 5'd3; rA2[0] = 5'd3;
    #1;
    chkVal("wr_rd1", d1a, 32'h12345678);
    chkVal("wr_rd2", d2a, 32'h12345678);
    step();

    // Bypass
    idle(); rA1[0] = 5'd9; we[0] = 1'b1; wA[0] = 5'd9; wD[0] = 32'hA5A5A5A5;
    #1;
    chkVal("bypass", d1a, 32'hA5A5A5A5);
    step();

    // Zero register vs. ordinary r0
    idle();
    for (int i = 0; i < 2; i++) begin
      we[i] = 1'b1; wA[i] = 5'd0; wD[i] = 32'hFFFFFFFF; rv[i] = 1'b1; vA[i] = 5'd0;
    end
    #1;
    chkVal("zero_wcyc_data", d1a, 32'h0);
    chkVal("zero_wcyc_busy", {31'h0, b1[0]}, 32'h0);
    chkVal("nz_wcyc_data", d1b, 32'hFFFFFFFF);
    step();
    idle();
    #1;
    chkVal("zero_data", d1a, 32'h0);
    chkVal("zero_busy", {31'h0, b1[0]}, 32'h0);
    chkVal("nz_data", d1b, 32'hFFFFFFFF);
    chkVal("nz_busy", {31'h0, b1[1]}, 32'h1);
    step();

    // Scoreboard set, combinational clear, same-edge set wins
    idle(); rA1[0] = 5'd4; rv[0] = 1'b1; vA[0] = 5'd4;
    #1;
    chkVal("sb_resv_same_cyc", {31'h0, b1[0]}, 32'h0);
    step();
    rv[0] = 1'b0;
    #1;
    chkVal("sb_set", {31'h0, b1[0]}, 32'h1);
    we[0] = 1'b1; wA[0] = 5'd4; wD[0] = 32'h00000044;
    #1;
    chkVal("sb_clr_comb", {31'h0, b1[0]}, 32'h0);
    step();
    we[0] = 1'b0;
    #1;
    chkVal("sb_clr", {31'h0, b1[0]}, 32'h0);
    we[0] = 1'b1; rv[0] = 1'b1; vA[0] = 5'd4;
    step();
    idle(); rA1[0] = 5'd4;
    #1;
    chkVal("sb_set_wins", {31'h0, b1[0]}, 32'h1);
    step();

    // Narrow build
    idle(); we[2] = 1'b1; wA[2] = 5'd7; wD[2] = 32'h0000BEEF;
    step();
    wA[2] = 5'd1; wD[2] = 32'h00001234;
    step();
    idle(); rA1[2] = 5'd7; rA2[2] = 5'd1;
    #1;
    chkVal("small_r7", {16'h0, d1c}, 32'h0000BEEF);
    chkVal("small_r1", {16'h0, d2c}, 32'h00001234);
    step();
    for (int a = 0; a < 8; a++) begin
      idle(); rv[2] = 1'b1; vA[2] = 5'(a);
      step();
    end
    for (int a = 1; a < 8; a += 2) begin
      idle(); we[2] = 1'b1; wA[2] = 5'(a); wD[2] = 32'(a);
      step();
    end
    for (int a = 0; a < 8; a++) begin
      idle(); rA1[2] = 5'(a);
      #1;
      chkVal($sformatf("small_pend%0d", a), {31'h0, b1[2]},
             {31'h0, (a != 0 && a % 2 == 0)});
      step();
    end

    // Random traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      rstN = ($urandom_range(0, 63) != 0);
      for (int i = 0; i < 3; i++) begin
        rA1[i] = randAddr(i);
        rA2[i] = ($urandom_range(0, 3) == 0) ? rA1[i] : randAddr(i);
        wA[i]  = randAddr(i);
        vA[i]  = ($urandom_range(0, 3) == 0) ? wA[i] : randAddr(i);
        we[i]  = 1'($urandom_range(0, 1));
        rv[i]  = 1'($urandom_range(0, 1));
        wD[i]  = (dw[i] == 16) ? {16'h0, 16'($urandom)} : $urandom;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised, clocked MIPS register file with two combinational read ports, one synchronous write port, write-to-read bypass, an optional hardwired-zero register and a per-register pending-write scoreboard. It sits in the decode stage. It supplies operands to the ALU path and reports whether each operand still has an outstanding producer, so the hazard logic can stall. It replaces the earlier asynchronous, unclocked register bank.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W registers
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never pending
- clk  in  1  clock; all state changes on rising edge
- rstN  in  1  reset, synchronous, active-low
- rAddr1  in  ADDR_W  read port 1 address
- rAddr2  in  ADDR_W  read port 2 address
- regData1  out  DATA_W  read port 1 data (combinational)
- regData2  out  DATA_W  read port 2 data (combinational)
- busy1  out  1  register at rAddr1 has an outstanding producer
- busy2  out  1  register at rAddr2 has an outstanding producer
- wAddr  in  ADDR_W  write address
- wrData  in  DATA_W  write data
- regWriteFlag  in  1  write wrData to wAddr this cycle; clears pending[wAddr]
- resvFlag  in  1  mark resvAddr pending (instruction issued with that destination)
- resvAddr  in  ADDR_W  destination being reserved

## Operation
- State: regs[0..2**ADDR_W-1] of DATA_W bits and pending[0..2**ADDR_W-1] of 1 bit each.
- Reset: rstN sampled low at a rising edge clears every regs entry to 0 and every pending bit to 0. Reset overrides any same-edge write or reservation.
- Write: at an edge with rstN=1 and regWriteFlag=1, regs[wAddr] <= wrData. It is suppressed when ZERO_REG=1 and wAddr=0.
- Read, per port n:
  - If ZERO_REG=1 and rAddrn=0: regDatan = 0.
  - Else if regWriteFlag=1 and wAddr=rAddrn: regDatan = wrData (bypass).
  - Else: regDatan = regs[rAddrn].
- Scoreboard update, at an edge with rstN=1:
  - regWriteFlag=1 clears pending[wAddr].
  - resvFlag=1 sets pending[resvAddr].
  - Same address both ways: set wins. The old producer retires as a new one issues, so the bit stays 1.
  - When ZERO_REG=1, address 0 is never set.
- Busy, per port n: busyn = pending[rAddrn] AND NOT (regWriteFlag AND wAddr=rAddrn). It is forced to 0 when ZERO_REG=1 and rAddrn=0. A same-cycle reservation does not affect busyn until the next cycle.
- Both read ports may address the same register; each port is evaluated independently.
- Reserving an already-pending register is legal; the bit remains 1. No producer counting.
- Writing a non-pending register is legal; the bit remains 0.

## Timing
- Read latency: 0 cycles, combinational from rAddrn, regs, wAddr, wrData, regWriteFlag.
- Write latency: 1 edge. A value written at edge k is visible from regs after edge k, and is visible through the bypass during the cycle before edge k.
- Scoreboard latency: a set or clear at edge k is reflected in pending after edge k. The write-clear is also reflected in busyn combinationally before edge k.
- Output values immediately after reset: regData1 = regData2 = 0 and busy1 = busy2 = 0, unless the bypass is active.
- Reset mid-operation: any in-flight reservations are discarded. No output is held across reset.
- There are no combinational paths from resvFlag or resvAddr to any output.

## Test plan
- Reset: preload regs[5] = 0xDEADBEEF and reserve r7. Assert rstN=0 for 1 edge while regWriteFlag=1, wAddr=5. -> After the edge, rAddr1=5 gives regData1=0, and rAddr2=7 gives busy2=0.
- Write/read: write 0x12345678 to r3. Next cycle, rAddr1=rAddr2=3 -> both regData = 0x12345678.
- Bypass: hold rAddr1=9 and drive regWriteFlag=1, wAddr=9, wrData=0xA5A5A5A5 in the same cycle -> regData1=0xA5A5A5A5 before the edge.
- Zero register (ZERO_REG=1):
  - Write 0xFFFFFFFF to r0 and reserve r0. -> rAddr1=0 gives regData1=0 and busy1=0, including during the write cycle.
  - Repeat with ZERO_REG=0. -> regData1=0xFFFFFFFF after the edge.
- Scoreboard:
  - resvFlag=1, resvAddr=4 at edge k. -> busy1=1 for rAddr1=4 after edge k.
  - In the cycle with regWriteFlag=1, wAddr=4. -> busy1=0 combinationally, and pending[4]=0 after the edge.
  - Same-edge write and reserve of r4. -> busy1=1 after the edge.
- Parametrisation: build DATA_W=16, ADDR_W=3, then write 0xBEEF to r7 and 0x1234 to r1. -> Both read back correctly, and all 8 pending bits set and clear independently.
